// File: rtl/ad_clk_pkg.sv
// Shared constants, widths and helpers for the behavioural ADC clock PLL model.
`timescale 1ns/1ps

package ad_clk_pkg;

    // Nominal reference and VCO frequencies, MHz
    localparam real CLKIN_FREQ = 50.0;
    localparam real VCO_FREQ   = 1000.0;

    // Output divider counter width
    localparam int unsigned DIV_W = 10;

    // Default lock qualification length and the counter width it needs
    localparam int unsigned LOCK_CYCLES_DEF = 64;

    function automatic int unsigned lock_w(input int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

    localparam int unsigned LOCK_W = lock_w(LOCK_CYCLES_DEF);

    typedef logic [DIV_W-1:0]  div_cnt_t;
    typedef logic [LOCK_W-1:0] lock_cnt_t;

    // True when a measured period t (ns) is within tol_ppm of the nominal tnom (ns)
    function automatic bit period_ok(input real t, input real tnom, input int unsigned tol_ppm);
        real err;
        err = t - tnom;
        if (err < 0.0) err = -err;
        return (err <= tnom * real'(tol_ppm) / 1.0e6);
    endfunction

endpackage

// File: rtl/ad_clk_odiv.sv
// Even-ratio VCO divider producing a 50% duty output, with an optional
// inverted phase that stays low until the divider has started.
`timescale 1ns/1ps

module ad_clk_odiv
    import ad_clk_pkg::*;
#(
    parameter int unsigned DIV_RATIO = 8,
    parameter bit          INVERT    = 1'b0
) (
    input  logic vco,
    input  logic run,
    output logic div
);

    if ((DIV_RATIO % 2) != 0 || DIV_RATIO < 2 || (DIV_RATIO / 2) > (2 ** DIV_W)) begin : g_bad_ratio
        $fatal(1, "ad_clk_odiv: DIV_RATIO must be even, >= 2 and fit the counter");
    end

    localparam div_cnt_t TERM = div_cnt_t'(DIV_RATIO / 2 - 1);

    div_cnt_t cnt;
    logic     q;
    logic     started;

    // Half-period counter; dropping run clears it immediately since the VCO stops with it
    always_ff @(posedge vco or negedge run) begin
        if (!run) begin
            cnt     <= '0;
            q       <= 1'b0;
            started <= 1'b0;
        end else if (cnt == TERM) begin
            cnt     <= '0;
            q       <= ~q;
            started <= 1'b1;
        end else begin
            cnt <= cnt + div_cnt_t'(1);
        end
    end

    // The inverted phase is held low until the first toggle so its first pulse is full width
    assign div = started & (q ^ INVERT);

endmodule

// File: rtl/ad_clock_125m_gen.sv
// Behavioural PLL model: qualifies the 50 MHz board clock, then runs an
// internal VCO and divides it into the 125 MHz / 125 MHz inverted / 25 MHz ADC clocks.
`timescale 1ns/1ps

module ad_clock_125m_gen
    import ad_clk_pkg::*;
#(
    parameter real         CLKIN_FREQ  = ad_clk_pkg::CLKIN_FREQ,
    parameter real         VCO_FREQ    = ad_clk_pkg::VCO_FREQ,
    parameter int unsigned ODIV0       = 8,
    parameter int unsigned ODIV1       = 8,
    parameter int unsigned ODIV2       = 40,
    parameter int unsigned LOCK_CYCLES = ad_clk_pkg::LOCK_CYCLES_DEF,
    parameter int unsigned TOL_PPM     = 10000
) (
    input  logic clkin1,
    input  logic pll_rst,
    output logic clkout0,
    output logic clkout1,
    output logic clkout2,
    output logic pll_lock
);

    localparam real         TNOM     = 1000.0 / CLKIN_FREQ;
    localparam real         VCO_HALF = 500.0 / VCO_FREQ;
    localparam int unsigned LW       = lock_w(LOCK_CYCLES);

    typedef logic [LW-1:0] lcnt_t;

    localparam lcnt_t LOCK_MAX  = lcnt_t'(LOCK_CYCLES);
    localparam lcnt_t LOCK_LAST = lcnt_t'(LOCK_CYCLES - 1);

    lcnt_t   good_cnt;
    logic    have_ts;
    realtime last_t;
    logic    vco;

    // Reference period check and sticky lock; reset wins over a good period on the same edge
    always_ff @(posedge clkin1) begin
        if (pll_rst) begin
            good_cnt <= '0;
            have_ts  <= 1'b0;
            last_t   <= 0.0;
            pll_lock <= 1'b0;
        end else begin
            have_ts <= 1'b1;
            last_t  <= $realtime;
            if (have_ts) begin
                if (period_ok($realtime - last_t, TNOM, TOL_PPM)) begin
                    if (good_cnt != LOCK_MAX) good_cnt <= good_cnt + lcnt_t'(1);
                    if (good_cnt == LOCK_LAST) pll_lock <= 1'b1;
                end else begin
                    good_cnt <= '0;
                end
            end
        end
    end

    // VCO: free-running while locked, parked low otherwise
    always begin : vco_osc
        vco = 1'b0;
        wait (pll_lock);
        while (pll_lock) begin
            #(VCO_HALF);
            if (pll_lock) vco = ~vco;
        end
    end

    ad_clk_odiv #(.DIV_RATIO(ODIV0), .INVERT(1'b0)) u_odiv0 (
        .vco (vco),
        .run (pll_lock),
        .div (clkout0)
    );

    ad_clk_odiv #(.DIV_RATIO(ODIV1), .INVERT(1'b1)) u_odiv1 (
        .vco (vco),
        .run (pll_lock),
        .div (clkout1)
    );

    ad_clk_odiv #(.DIV_RATIO(ODIV2), .INVERT(1'b0)) u_odiv2 (
        .vco (vco),
        .run (pll_lock),
        .div (clkout2)
    );

endmodule

// File: tb/tb_ad_clock_125m_gen.sv
// Directed bench for ad_clock_125m_gen: lock timing, output waveforms,
// reset behaviour, off-frequency input and a single glitched period.
`timescale 1ns/1ps

module tb_ad_clock_125m_gen;

    logic clkin1 = 1'b0;
    logic pll_rst = 1'b1;
    logic clkout0, clkout1, clkout2, pll_lock;
    logic [2:0] co;

    real half_hi = 10.0;
    real half_lo = 10.0;

    int n_cmp = 0;
    int n_err = 0;
    int lock_rises = 0;
    realtime arm_t = 1.0e12;

    ad_clock_125m_gen u_dut (
        .clkin1   (clkin1),
        .pll_rst  (pll_rst),
        .clkout0  (clkout0),
        .clkout1  (clkout1),
        .clkout2  (clkout2),
        .pll_lock (pll_lock)
    );

    assign co = {clkout2, clkout1, clkout0};

    // Reference clock; each phase length is read at the start of that phase
    always begin
        clkin1 = 1'b1;
        #(half_hi);
        clkin1 = 1'b0;
        #(half_lo);
    end

    always @(posedge pll_lock) lock_rises++;

    // Per-output edge timestamps and runt detection while armed
    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam real NH = (g == 2) ? 20.0 : 4.0;
        realtime r_t = 0.0;
        realtime f_t = 0.0;
        realtime per = 0.0;
        realtime hi  = 0.0;
        int runts_lo = 0;
        int runts_hi = 0;
        int pulses   = 0;
        always @(posedge co[g]) begin
            per = $realtime - r_t;
            if (f_t > arm_t && ($realtime - f_t) < NH - 0.001) runts_lo++;
            r_t = $realtime;
        end
        always @(negedge co[g]) begin
            hi = $realtime - r_t;
            if (r_t > arm_t) begin
                pulses++;
                if (hi < NH - 0.001) runts_hi++;
            end
            f_t = $realtime;
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clkin1);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_t(input string tag, input real obs, input real exp);
        n_cmp++;
        assert ((obs - exp) <= 0.001 && (exp - obs) <= 0.001) else begin
            n_err++;
            $error("FAIL %s: observed %0.4f expected %0.4f", tag, obs, exp);
        end
    endtask

    initial begin
        int bad;

        // 1: reset, then lock exactly 64 good periods after the timestamp edge
        pll_rst = 1'b1;
        wait_edges(3);
        chk("rst_lock", pll_lock, 0);
        chk("rst_clkout0", clkout0, 0);
        chk("rst_clkout1", clkout1, 0);
        chk("rst_clkout2", clkout2, 0);
        pll_rst = 1'b0;
        wait_edges(64);
        chk("t1_lock_early", pll_lock, 0);
        wait_edges(1);
        chk("t1_lock", pll_lock, 1);

        // 2: waveforms; lock edge L, clkout0 rises L+3.5+8m, clkout2 rises L+19.5+40m
        chk("t2_start_zero", {29'd0, co}, 0);
        #4;
        chk("t2_c0_hi", clkout0, 1);
        chk("t2_c1_lo", clkout1, 0);
        #4;
        chk("t2_c0_lo", clkout0, 0);
        chk("t2_c1_hi", clkout1, 1);
        #12;
        chk("t2_c2_hi", clkout2, 1);
        chk("t2_c0_hi2", clkout0, 1);
        #40;
        chk_t("t2_c0_period", g_mon[0].per, 8.0);
        chk_t("t2_c0_high", g_mon[0].hi, 4.0);
        chk_t("t2_c2_period", g_mon[2].per, 40.0);
        chk_t("t2_c2_align", g_mon[2].r_t, g_mon[0].r_t);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (clkout1 !== ~clkout0) bad++;
            #1;
        end
        chk("t2_c1_inverse", bad, 0);
        chk("t2_lock_rises", lock_rises, 1);

        // 4: reset while locked, relock with no runt pulses
        pll_rst = 1'b1;
        wait_edges(1);
        chk("t4_rst_out", {28'd0, pll_lock, co}, 0);
        pll_rst = 1'b0;
        arm_t = $realtime;
        wait_edges(64);
        chk("t4_lock_early", pll_lock, 0);
        wait_edges(1);
        chk("t4_lock", pll_lock, 1);
        chk("t4_lock_rises", lock_rises, 2);
        #120;
        chk("t4_runt_c0", g_mon[0].runts_hi + g_mon[0].runts_lo, 0);
        chk("t4_runt_c1", g_mon[1].runts_hi + g_mon[1].runts_lo, 0);
        chk("t4_runt_c2", g_mon[2].runts_hi + g_mon[2].runts_lo, 0);
        chk("t4_pulses_seen",
            int'(g_mon[0].pulses > 0 && g_mon[1].pulses > 0 && g_mon[2].pulses > 0), 1);
        arm_t = 1.0e12;

        // 3: reset held 5 edges partway through acquisition
        pll_rst = 1'b1;
        wait_edges(1);
        pll_rst = 1'b0;
        wait_edges(30);
        chk("t3_partial", pll_lock, 0);
        pll_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_edges(1);
            chk("t3_hold", {28'd0, pll_lock, co}, 0);
        end
        pll_rst = 1'b0;
        wait_edges(64);
        chk("t3_lock_early", pll_lock, 0);
        wait_edges(1);
        chk("t3_lock", pll_lock, 1);

        // 6: one 15 ns period after 40 good periods restarts qualification
        pll_rst = 1'b1;
        wait_edges(1);
        pll_rst = 1'b0;
        wait_edges(41);
        half_lo = 5.0;
        wait_edges(1);
        half_lo = 10.0;
        wait_edges(63);
        chk("t6_lock_early", pll_lock, 0);
        wait_edges(1);
        chk("t6_lock", pll_lock, 1);

        // 5: 40 MHz input never qualifies; back at 50 MHz it locks
        pll_rst = 1'b1;
        wait_edges(1);
        pll_rst = 1'b0;
        half_hi = 12.5;
        half_lo = 12.5;
        for (int i = 0; i < 10; i++) begin
            wait_edges(20);
            chk("t5_40mhz", {28'd0, pll_lock, co}, 0);
        end
        half_hi = 10.0;
        half_lo = 10.0;
        wait_edges(1);
        wait_edges(63);
        chk("t5_lock_early", pll_lock, 0);
        wait_edges(1);
        chk("t5_lock", pll_lock, 1);
        chk("t5_lock_rises", lock_rises, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
